// File: rtl/cache_refill_responder.sv
`default_nettype none
// ============================================================================
// cache_refill_responder : memory-side refill/write-through responder; owns the RAM word array.
// Option macro: CACHE_REFILL_CRITICAL_WORD_FIRST_EN (burst starts at the missed word and wraps).
// Revision: 1.0
// ============================================================================
module cache_refill_responder #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int READ_LATENCY     = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    input  logic [RAM_ADDRESS_BITS-1:0] req_address,
    output logic                        req_ready,
    input  logic                        wr_en,
    input  logic [RAM_ADDRESS_BITS-1:0] wr_address,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        wr_ready,
    output logic                        refill_valid,
    output logic [DATA_BITS-1:0]        refill_data,
    output logic [BLOCK_BITS-1:0]       refill_offset,
    output logic [RAM_ADDRESS_BITS-1:0] refill_address,
    output logic                        refill_last,
    output logic                        busy
);

    localparam int DEPTH    = 2 ** RAM_ADDRESS_BITS;
    localparam int TAG_BITS = RAM_ADDRESS_BITS - BLOCK_BITS;
    localparam int LAT_BITS = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    if (READ_LATENCY < 1 || BLOCK_BITS >= RAM_ADDRESS_BITS) begin : g_param_check
        $error("cache_refill_responder: READ_LATENCY must be >= 1 and BLOCK_BITS < RAM_ADDRESS_BITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                       r_state, w_state_next;
    logic [LAT_BITS-1:0]          r_lat, w_lat_next;
    logic [TAG_BITS-1:0]          r_block, w_block_next;
    logic [BLOCK_BITS-1:0]        r_off, w_off_next;
    logic [BLOCK_BITS-1:0]        r_beat, w_beat_next;
    logic                         r_valid, w_valid_next;
    logic [DATA_BITS-1:0]         r_data, w_data_next;
    logic [BLOCK_BITS-1:0]        r_offset, w_offset_next;
    logic [RAM_ADDRESS_BITS-1:0]  r_address, w_address_next;
    logic                         r_last, w_last_next;
    logic                         w_issue;
    logic                         w_wr_commit;
    logic [BLOCK_BITS-1:0]        w_start_off;
    logic [RAM_ADDRESS_BITS-1:0]  w_rd_addr;
    logic [DATA_BITS-1:0]         w_rd_data;
    logic [DATA_BITS-1:0]         w_mem [DEPTH];

    assign req_ready = (r_state == ST_IDLE);
    assign wr_ready  = (r_state != ST_BURST);
    assign busy      = (r_state != ST_IDLE);

    // Writes presented while reset is asserted must not land in the array.
    assign w_wr_commit = reset_n && wr_en && wr_ready;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign w_start_off = req_address[BLOCK_BITS-1:0];
`else
    logic w_unused_req_offset;
    assign w_start_off         = '0;
    assign w_unused_req_offset = ^req_address[BLOCK_BITS-1:0];
`endif

    // Each word powers up holding its own address; reset never touches the array.
    for (genvar a = 0; a < DEPTH; a++) begin : g_word
        logic [DATA_BITS-1:0] r_word = DATA_BITS'(a);
        always_ff @(posedge clk) begin
            if (w_wr_commit && (wr_address == RAM_ADDRESS_BITS'(a))) begin
                r_word <= wr_data;
            end
        end
        assign w_mem[a] = r_word;
    end

    // Forward a same-edge write so a beat never returns the pre-write word.
    assign w_rd_addr = {r_block, r_off};
    assign w_rd_data = (w_wr_commit && (wr_address == w_rd_addr)) ? wr_data : w_mem[w_rd_addr];

    always_comb begin
        w_state_next   = r_state;
        w_lat_next     = r_lat;
        w_block_next   = r_block;
        w_off_next     = r_off;
        w_beat_next    = r_beat;
        w_issue        = 1'b0;
        w_valid_next   = 1'b0;
        w_data_next    = '0;
        w_offset_next  = '0;
        w_address_next = '0;
        w_last_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = ST_WAIT;
                    w_lat_next   = LAT_BITS'(READ_LATENCY - 1);
                    w_block_next = req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                    w_off_next   = w_start_off;
                    w_beat_next  = '0;
                end
            end
            ST_WAIT: begin
                if (r_lat == '0) begin
                    w_state_next = ST_BURST;
                    w_issue      = 1'b1;
                end else begin
                    w_lat_next = r_lat - LAT_BITS'(1);
                end
            end
            ST_BURST: begin
                if (r_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_issue) begin
            w_valid_next   = 1'b1;
            w_data_next    = w_rd_data;
            w_offset_next  = r_off;
            w_address_next = {r_block, {BLOCK_BITS{1'b0}}};
            w_last_next    = (r_beat == {BLOCK_BITS{1'b1}});
            w_off_next     = r_off + BLOCK_BITS'(1);
            w_beat_next    = r_beat + BLOCK_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_lat     <= '0;
            r_block   <= '0;
            r_off     <= '0;
            r_beat    <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_offset  <= '0;
            r_address <= '0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lat     <= w_lat_next;
            r_block   <= w_block_next;
            r_off     <= w_off_next;
            r_beat    <= w_beat_next;
            r_valid   <= w_valid_next;
            r_data    <= w_data_next;
            r_offset  <= w_offset_next;
            r_address <= w_address_next;
            r_last    <= w_last_next;
        end
    end

    assign refill_valid   = r_valid;
    assign refill_data    = r_data;
    assign refill_offset  = r_offset;
    assign refill_address = r_address;
    assign refill_last    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_responder.sv
`default_nettype none
// ============================================================================
// tb_cache_refill_responder : directed scoreboard bench for cache_refill_responder.
// Revision: 1.0
// ============================================================================
module tb_cache_refill_responder;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BB  = 2;
    localparam int LAT = 3;
    localparam int BS  = 4;
    localparam int PERIOD = LAT + BS + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] wr_data = '0;
    logic          req_ready, wr_ready, refill_valid, refill_last, busy;
    logic [DW-1:0] refill_data;
    logic [BB-1:0] refill_offset;
    logic [AW-1:0] refill_address;

    always #5 clk = ~clk;

    cache_refill_responder #(
        .RAM_ADDRESS_BITS (AW),
        .DATA_BITS        (DW),
        .BLOCK_BITS       (BB),
        .READ_LATENCY     (LAT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_address    (req_address),
        .req_ready      (req_ready),
        .wr_en          (wr_en),
        .wr_address     (wr_address),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .refill_valid   (refill_valid),
        .refill_data    (refill_data),
        .refill_offset  (refill_offset),
        .refill_address (refill_address),
        .refill_last    (refill_last),
        .busy           (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [BB-1:0] off;
        logic [AW-1:0] addr;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t         sb[$];
    logic [DW-1:0] model [2**AW];
    int            cyc = 0;
    int            n_assert = 0;
    int            n_fail = 0;
    int            beats_pushed = 0;
    int            beats_seen = 0;
    bit            mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected beats come from the bench's own memory model at acceptance time.
    task automatic push_burst(input logic [AW-1:0] addr, input int e0, input int nbeats);
        logic [BB-1:0] start;
        logic [BB-1:0] off;
        logic [AW-1:0] a;
        beat_t         e;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        start = addr[BB-1:0];
`else
        start = '0;
`endif
        for (int k = 0; k < nbeats; k++) begin
            off    = start + BB'(k);
            a      = {addr[AW-1:BB], off};
            e.data = model[a];
            e.off  = off;
            e.addr = {addr[AW-1:BB], {BB{1'b0}}};
            e.last = (k == BS - 1);
            e.cyc  = e0 + LAT + k;
            sb.push_back(e);
            beats_pushed++;
        end
    endtask

    task automatic do_req(input logic [AW-1:0] addr, input int nbeats);
        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_address = addr;
        push_burst(addr, cyc + 1, nbeats);
        tick();
        req_valid = 1'b0;
        chk("req_ready_drop", 32'(req_ready), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("burst_timeout", 32'(n < 60), 32'd1);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(refill_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (refill_valid === 1'b1) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat_queue", 32'(sb.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_data", refill_data, e.data);
                    chk("beat_offset", 32'(refill_offset), 32'(e.off));
                    chk("beat_address", 32'(refill_address), 32'(e.addr));
                    chk("beat_last", 32'(refill_last), 32'(e.last));
                    chk("beat_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("hold_data", refill_data, 32'd0);
                chk("hold_offset", 32'(refill_offset), 32'd0);
                chk("hold_last", 32'(refill_last), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e0;
        for (int a = 0; a < 2**AW; a++) model[a] = DW'(a);

        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(refill_valid), 32'd0);
        chk("rst_data", refill_data, 32'd0);
        chk("rst_offset", 32'(refill_offset), 32'd0);
        chk("rst_address", 32'(refill_address), 32'd0);
        chk("rst_last", 32'(refill_last), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // Plain miss, then a miss in the middle of a block.
        do_req(10'h005, BS);
        wait_idle();
        do_req(10'h006, BS);
        wait_idle();

        // Write and request accepted on the same IDLE edge.
        wr_en      = 1'b1;
        wr_address = 10'h105;
        wr_data    = 32'hDEADBEEF;
        model[10'h105] = 32'hDEADBEEF;
        do_req(10'h104, BS);
        wr_en = 1'b0;
        wait_idle();

        // Write held through a burst is stalled until IDLE.
        do_req(10'h030, BS);
        repeat (3) tick();
        wr_en      = 1'b1;
        wr_address = 10'h010;
        wr_data    = 32'h00001234;
        for (int i = 0; i < BS; i++) begin
            chk("wr_ready_burst", 32'(wr_ready), 32'd0);
            tick();
        end
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        model[10'h010] = 32'h00001234;
        wr_en = 1'b0;
        chk("queue_after_stall", 32'(sb.size()), 32'd0);
        do_req(10'h010, BS);
        wait_idle();

        // Reset during beat 2; writes offered under reset must be dropped.
        do_req(10'h020, 3);
        repeat (5) tick();
        reset_n    = 1'b0;
        wr_en      = 1'b1;
        wr_address = 10'h021;
        wr_data    = 32'hBAD0BAD0;
        tick();
        chk("midrst_valid", 32'(refill_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
        chk("midrst_queue", 32'(sb.size()), 32'd0);
        tick();
        reset_n = 1'b1;
        wr_en   = 1'b0;
        tick();
        do_req(10'h020, BS);
        wait_idle();

        // req_valid held: one acceptance per burst with one idle cycle between.
        chk("held_req_ready", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_address = 10'h040;
        e0 = cyc + 1;
        push_burst(10'h040, e0, BS);
        push_burst(10'h040, e0 + PERIOD, BS);
        push_burst(10'h040, e0 + 2 * PERIOD, BS);
        repeat (2 * PERIOD + 1) tick();
        req_valid = 1'b0;
        wait_idle();

        // Request pulses during WAIT are dropped.
        do_req(10'h050, BS);
        req_valid   = 1'b1;
        req_address = 10'h060;
        tick();
        req_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_idle();
        repeat (12) tick();

        chk("beat_count", 32'(beats_seen), 32'(beats_pushed));
        chk("queue_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
